// File: rtl/collide_score_ctrl_if.sv
// Per-pixel overlap flags and restart in, explode/life/score state out, for the tank collision controller.
// master: pixel pipeline side; slave: collide_score_ctrl.
interface collide_score_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_ENEMIES = 4,
  parameter int SCORE_W     = 11
);
  logic                           restart_i;
  logic [NUM_PLAYERS-1:0]         player_box_i;
  logic [NUM_PLAYERS-1:0]         player_bullet_i;
  logic [NUM_ENEMIES-1:0]         enemy_box_i;
  logic [NUM_ENEMIES-1:0]         enemy_bullet_i;
  logic                           hard_block_i;
  logic                           destroyable_block_i;
  logic                           eagle_block_i;

  logic [NUM_PLAYERS-1:0]         player_explode_o;
  logic [NUM_PLAYERS-1:0]         player_die_o;
  logic [NUM_PLAYERS-1:0]         player_revive_o;
  logic [NUM_PLAYERS-1:0]         player_alive_o;
  logic [NUM_ENEMIES-1:0]         enemy_explode_o;
  logic [NUM_ENEMIES-1:0]         enemy_die_o;
  logic [NUM_ENEMIES-1:0]         enemy_revive_o;
  logic [NUM_ENEMIES-1:0]         enemy_alive_o;
  logic [4*NUM_PLAYERS-1:0]       player_lives_o;
  logic [SCORE_W*NUM_PLAYERS-1:0] player_score_o;
  logic [3:0]                     enemies_left_o;
  logic                           wall_hit_o;
  logic                           eagle_hit_o;
  logic                           game_over_o;

  modport master (
    output restart_i, player_box_i, player_bullet_i, enemy_box_i, enemy_bullet_i,
           hard_block_i, destroyable_block_i, eagle_block_i,
    input  player_explode_o, player_die_o, player_revive_o, player_alive_o,
           enemy_explode_o, enemy_die_o, enemy_revive_o, enemy_alive_o,
           player_lives_o, player_score_o, enemies_left_o,
           wall_hit_o, eagle_hit_o, game_over_o
  );

  modport slave (
    input  restart_i, player_box_i, player_bullet_i, enemy_box_i, enemy_bullet_i,
           hard_block_i, destroyable_block_i, eagle_block_i,
    output player_explode_o, player_die_o, player_revive_o, player_alive_o,
           enemy_explode_o, enemy_die_o, enemy_revive_o, enemy_alive_o,
           player_lives_o, player_score_o, enemies_left_o,
           wall_hit_o, eagle_hit_o, game_over_o
  );
endinterface

// File: rtl/collide_score_ctrl.sv
// Tank collision, life FSM and scoring; define COLLIDE_FRIENDLY_FIRE_EN to let player bullets hit other players.
// Latency: die/score/eagle 1 clk after the hit pixel, game_over 1 clk later; no backpressure, flags sampled every clock.
module collide_score_ctrl #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_ENEMIES   = 4,
  parameter int LIVES_INIT    = 3,
  parameter int REVIVE_CYCLES = 1000000,
  parameter int SCORE_W       = 11,
  parameter int KILL_POINTS   = 10,
  parameter int BLOCK_POINTS  = 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  collide_score_ctrl_if.slave bus
);
  localparam int                N         = NUM_PLAYERS + NUM_ENEMIES;
  localparam int                CNT_W     = $clog2(REVIVE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REVIVE_CYCLES - 1);
  localparam logic [3:0]        LIVES_RST = 4'(LIVES_INIT);
  localparam int                SCORE_MAX = (1 << SCORE_W) - 1;

  typedef enum logic [1:0] {LIVING, DEAD, WAIT, OVER} state_t;
  localparam state_t STATE_RST = (LIVES_INIT == 0) ? OVER : LIVING;

  state_t             state_q [N];
  logic [3:0]         lives_q [N];
  logic [CNT_W-1:0]   cnt_q   [N];
  logic [N-1:0]       die_q, revive_q, living, hit;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
  logic               eagle_q, game_over_q;

  logic                           any_pb, any_eb, any_pbox, any_ebox, all_players_over;
  logic [NUM_PLAYERS-1:0]         p_expl;
  logic [NUM_ENEMIES-1:0]         e_expl;
  logic [3:0]                     left;
  logic [31:0]                    sum;
  logic                           kill;
  logic [4*NUM_PLAYERS-1:0]       lives_pack;
  logic [SCORE_W*NUM_PLAYERS-1:0] score_pack;
`ifdef COLLIDE_FRIENDLY_FIRE_EN
  logic [NUM_PLAYERS-1:0]         mates_box, mates_bullet;
`endif

  assign any_pb   = |bus.player_bullet_i;
  assign any_eb   = |bus.enemy_bullet_i;
  assign any_pbox = |bus.player_box_i;
  assign any_ebox = |bus.enemy_box_i;

  always_comb begin
    hit    = '0;
    p_expl = '0;
    e_expl = '0;
`ifdef COLLIDE_FRIENDLY_FIRE_EN
    mates_box    = '0;
    mates_bullet = '0;
`endif
    for (int p = 0; p < NUM_PLAYERS; p++) begin
`ifdef COLLIDE_FRIENDLY_FIRE_EN
      // a player's own bullet leaving its own box is not a collision
      mates_box       = bus.player_box_i;
      mates_box[p]    = 1'b0;
      mates_bullet    = bus.player_bullet_i;
      mates_bullet[p] = 1'b0;
      hit[p]    = bus.player_box_i[p] && (any_eb || |mates_bullet);
      p_expl[p] = bus.player_bullet_i[p] &&
                  (bus.hard_block_i || any_ebox || any_eb || |mates_box);
`else
      hit[p]    = bus.player_box_i[p] && any_eb;
      p_expl[p] = bus.player_bullet_i[p] && (bus.hard_block_i || any_ebox || any_eb);
`endif
    end
    for (int e = 0; e < NUM_ENEMIES; e++) begin
      hit[NUM_PLAYERS+e] = bus.enemy_box_i[e] && any_pb;
      e_expl[e]          = bus.enemy_bullet_i[e] && (bus.hard_block_i || any_pbox || any_pb);
    end
  end

  always_comb begin
    living           = '0;
    left             = '0;
    all_players_over = 1'b1;
    for (int i = 0; i < N; i++) living[i] = (state_q[i] == LIVING);
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (state_q[p] != OVER) all_players_over = 1'b0;
    for (int e = 0; e < NUM_ENEMIES; e++)
      left = left + 4'(state_q[NUM_PLAYERS+e] != OVER);
  end

  // Kill and block points add in one cycle; the 32-bit sum lets saturation see the overflow.
  always_comb begin
    sum  = '0;
    kill = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      kill = bus.player_bullet_i[p] && |(bus.enemy_box_i & living[N-1:NUM_PLAYERS]);
      sum  = 32'(score_q[p])
           + (kill ? 32'(KILL_POINTS) : 32'd0)
           + ((bus.player_bullet_i[p] && bus.destroyable_block_i) ? 32'(BLOCK_POINTS) : 32'd0);
      score_d[p] = (sum > 32'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= STATE_RST;
        lives_q[i] <= LIVES_RST;
        cnt_q[i]   <= '0;
      end
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
      die_q       <= '0;
      revive_q    <= '0;
      eagle_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else if (bus.restart_i) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= STATE_RST;
        lives_q[i] <= LIVES_RST;
        cnt_q[i]   <= '0;
      end
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
      die_q       <= '0;
      revive_q    <= '0;
      eagle_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= score_d[p];
      eagle_q     <= eagle_q || (bus.eagle_block_i && (any_pb || any_eb));
      game_over_q <= eagle_q || all_players_over;
      die_q       <= '0;
      revive_q    <= '0;
      for (int i = 0; i < N; i++) begin
        case (state_q[i])
          LIVING: if (hit[i]) begin
            state_q[i] <= DEAD;
            die_q[i]   <= 1'b1;
          end
          DEAD: begin
            cnt_q[i] <= '0;
            if (lives_q[i] <= 4'd1) begin
              lives_q[i] <= 4'd0;
              state_q[i] <= OVER;
            end else begin
              lives_q[i] <= lives_q[i] - 4'd1;
              state_q[i] <= WAIT;
            end
          end
          WAIT: if (cnt_q[i] == CNT_LAST) begin
            state_q[i]  <= LIVING;
            revive_q[i] <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    lives_pack = '0;
    score_pack = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      lives_pack[4*p +: 4]             = lives_q[p];
      score_pack[SCORE_W*p +: SCORE_W] = score_q[p];
    end
  end

  assign bus.player_explode_o = p_expl;
  assign bus.enemy_explode_o  = e_expl;
  assign bus.player_die_o     = die_q[NUM_PLAYERS-1:0];
  assign bus.enemy_die_o      = die_q[N-1:NUM_PLAYERS];
  assign bus.player_revive_o  = revive_q[NUM_PLAYERS-1:0];
  assign bus.enemy_revive_o   = revive_q[N-1:NUM_PLAYERS];
  assign bus.player_alive_o   = living[NUM_PLAYERS-1:0];
  assign bus.enemy_alive_o    = living[N-1:NUM_PLAYERS];
  assign bus.player_lives_o   = lives_pack;
  assign bus.player_score_o   = score_pack;
  assign bus.enemies_left_o   = left;
  assign bus.wall_hit_o       = bus.destroyable_block_i && (any_pb || any_eb);
  assign bus.eagle_hit_o      = eagle_q;
  assign bus.game_over_o      = game_over_q;
endmodule

// File: doc/collide_score_ctrl.md
COLLIDE_SCORE_CTRL -- requirements
Module: collide_score_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of player tanks (1..4).
REQ-002 SHALL have parameter NUM_ENEMIES, default 4, number of enemy tanks (1..8).
REQ-003 SHALL have parameter LIVES_INIT, default 3, lives per entity at reset/restart (4-bit).
REQ-004 SHALL have parameter REVIVE_CYCLES, default 1000000, WAIT duration in clocks (>=2).
REQ-005 SHALL have parameters SCORE_W default 11, KILL_POINTS default 10, BLOCK_POINTS default 1.
REQ-006 SHALL have ports: clk_i in 1 clock; reset_ni in 1 async active-low reset; one clock, reset asynchronous active-low.
REQ-007 SHALL have ports: restart_i in 1 sync game restart; player_box_i/player_bullet_i in NUM_PLAYERS pixel overlap flags; enemy_box_i/enemy_bullet_i in NUM_ENEMIES.
REQ-008 SHALL have ports: hard_block_i, destroyable_block_i, eagle_block_i in 1 each, current-pixel terrain flags.
REQ-009 SHALL have ports: player_explode_o/player_die_o/player_revive_o/player_alive_o out NUM_PLAYERS; enemy_explode_o/enemy_die_o/enemy_revive_o/enemy_alive_o out NUM_ENEMIES.
REQ-010 SHALL have ports: player_lives_o out 4*NUM_PLAYERS; player_score_o out SCORE_W*NUM_PLAYERS; enemies_left_o out 4; wall_hit_o, eagle_hit_o, game_over_o out 1.

Function
REQ-011 Per-entity FSM states SHALL be LIVING, DEAD, WAIT, OVER.
REQ-012 LIVING->DEAD SHALL occur on the clock after a hit; hits SHALL be ignored in DEAD/WAIT/OVER (invulnerable).
REQ-013 Player p hit = player_box_i[p] && any enemy_bullet_i; enemy e hit = enemy_box_i[e] && any player_bullet_i.
REQ-014 DEAD SHALL last exactly 1 cycle: die_o high that cycle, lives decremented at its end, next state OVER if new lives==0 else WAIT.
REQ-015 WAIT SHALL last exactly REVIVE_CYCLES cycles, then LIVING; revive_o SHALL pulse 1 cycle in first LIVING cycle.
REQ-016 alive_o SHALL be high exactly in LIVING; OVER SHALL be terminal until restart_i or reset.
REQ-017 Explode (combinational) for player bullet p: bullet && (hard_block || any box || any enemy bullet); enemy bullet e: bullet && (hard_block || any box || any player bullet).
REQ-018 wall_hit_o SHALL be destroyable_block_i && any bullet, combinational.
REQ-019 eagle_hit_o SHALL be sticky, set the cycle after eagle_block_i && any bullet, cleared only by reset/restart.
REQ-020 game_over_o SHALL be eagle_hit_o || all players in OVER, registered.
REQ-021 enemies_left_o SHALL equal count of enemies not in OVER.
REQ-022 Player p score SHALL add KILL_POINTS if its bullet overlaps any LIVING enemy box, plus BLOCK_POINTS if its bullet overlaps destroyable_block_i; both in the same cycle SHALL sum.
REQ-023 Scores SHALL saturate at 2^SCORE_W-1, never wrap.
REQ-024 Lives SHALL never decrement below 0; LIVES_INIT=0 SHALL place the entity in OVER after reset.
REQ-025 restart_i SHALL take priority over all hits: next cycle states LIVING, lives LIVES_INIT, scores 0, eagle_hit cleared, counters 0.

Reset
REQ-026 On reset_ni low, asynchronously: all FSMs LIVING (OVER if LIVES_INIT==0), lives=LIVES_INIT, scores=0, counters=0, die/revive=0, eagle_hit/game_over=0.
REQ-027 Reset mid-WAIT SHALL abort revival with no revive_o pulse.

Configuration
REQ-028 Macro COLLIDE_FRIENDLY_FIRE_EN defined: player p also hit by player_bullet_i[q], q!=p, no score awarded; undefined: player bullets never hit players and do not explode on player boxes.

Verification
REQ-029 Defaults, REVIVE_CYCLES=8: enemy_box_i[2]&&player_bullet_i[0] 1 cycle -> enemy_die_o[2] next cycle, score0=10, revive_o[2] 9 cycles after die.
REQ-030 Player 1 hit 3 times, each after revival -> lives 2,1,0; third DEAD -> OVER; game_over_o only after player 0 also OVER.
REQ-031 Hit repeated during WAIT -> no die_o, lives unchanged.
REQ-032 SCORE_W=4, score 14, kill+block same cycle -> score 15 (saturated).
REQ-033 eagle_block_i with enemy bullet -> eagle_hit_o and game_over_o set; restart_i -> cleared, lives 3.
REQ-034 With COLLIDE_FRIENDLY_FIRE_EN, player_bullet_i[0]&&player_box_i[1] -> player_die_o[1], score0 unchanged; without: no die.
